// File: rtl/sdram_port_arbiter.sv
// Three-way arbiter sharing one toggle-handshake SDRAM port between download, CPU and cassette.
// Fixed priority dl > cpu > cas, with a bounded CPU run so a pending cassette read is never starved.
module sdram_port_arbiter #(
  parameter int AW          = 25,
  parameter int CPU_MAX_RUN = 4
) (
  input  logic          clk_sys,
  input  logic          reset,
  input  logic          dl_req,
  output logic          dl_ack,
  input  logic [AW-1:0] dl_a,
  input  logic [7:0]    dl_d,
  input  logic          cpu_req,
  output logic          cpu_ack,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_a,
  input  logic [7:0]    cpu_d,
  output logic [7:0]    cpu_q,
  input  logic          cas_req,
  output logic          cas_ack,
  input  logic [AW-1:0] cas_a,
  output logic [7:0]    cas_q,
  output logic          mem_req,
  input  logic          mem_ack,
  output logic          mem_we,
  output logic [AW-1:0] mem_a,
  output logic [1:0]    mem_ds,
  output logic [15:0]   mem_d,
  input  logic [15:0]   mem_q,
  output logic          busy,
  output logic [1:0]    grant
);

  localparam int RW = $clog2(CPU_MAX_RUN + 1);
  localparam logic [RW-1:0] RUN_MAX = RW'(CPU_MAX_RUN);

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_DL   = 2'd1;
  localparam logic [1:0] OWN_CPU  = 2'd2;
  localparam logic [1:0] OWN_CAS  = 2'd3;

  typedef enum logic {IDLE, WAIT} state_t;

  state_t        state;
  logic [RW-1:0] run;

  logic pend_dl, pend_cpu, pend_cas;
  assign pend_dl  = dl_req ^ dl_ack;
  assign pend_cpu = cpu_req ^ cpu_ack;
  assign pend_cas = cas_req ^ cas_ack;

  logic [1:0]    winner;
  logic [AW-1:0] win_a;
  logic [7:0]    win_d;
  logic          win_we;
  logic [7:0]    rd_byte;

  // The run limit only bites while the cassette is actually waiting.
  always_comb begin
    winner = OWN_NONE;
    if (pend_dl)                         winner = OWN_DL;
    else if (pend_cas && run == RUN_MAX) winner = OWN_CAS;
    else if (pend_cpu)                   winner = OWN_CPU;
    else if (pend_cas)                   winner = OWN_CAS;
  end

  always_comb begin
    win_a  = cas_a;
    win_d  = 8'h00;
    win_we = 1'b0;
    case (winner)
      OWN_DL: begin
        win_a  = dl_a;
        win_d  = dl_d;
        win_we = 1'b1;
      end
      OWN_CPU: begin
        win_a  = cpu_a;
        win_d  = cpu_d;
        win_we = cpu_we;
      end
      default: ;
    endcase
  end

  assign rd_byte = mem_a[0] ? mem_q[7:0] : mem_q[15:8];

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      run     <= '0;
      dl_ack  <= 1'b0;
      cpu_ack <= 1'b0;
      cas_ack <= 1'b0;
      cpu_q   <= 8'h00;
      cas_q   <= 8'h00;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      mem_a   <= '0;
      mem_ds  <= 2'b00;
      mem_d   <= 16'h0000;
      busy    <= 1'b0;
      grant   <= OWN_NONE;
    end else begin
      case (state)
        IDLE: begin
          if (!pend_cas) run <= '0;
          if (winner != OWN_NONE) begin
            if (winner == OWN_CAS)
              run <= '0;
            else if (winner == OWN_CPU && pend_cas && run != RUN_MAX)
              run <= run + 1'b1;
            mem_a  <= win_a;
            mem_we <= win_we;
            mem_ds <= {~win_a[0], win_a[0]};
            // Cassette is read-only; leave the write bus as it was.
            if (winner != OWN_CAS) mem_d <= {win_d, win_d};
            mem_req <= ~mem_req;
            busy    <= 1'b1;
            grant   <= winner;
            state   <= WAIT;
          end
        end
        WAIT: begin
          if (mem_ack == mem_req) begin
            case (grant)
              OWN_DL:  dl_ack <= ~dl_ack;
              OWN_CPU: begin
                cpu_ack <= ~cpu_ack;
                if (!mem_we) cpu_q <= rd_byte;
              end
              OWN_CAS: begin
                cas_ack <= ~cas_ack;
                cas_q   <= rd_byte;
              end
              default: ;
            endcase
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Self-checking bench for sdram_port_arbiter: transaction-level reference model,
// toggle-handshake memory responder, directed vectors and randomized traffic.
module tb_sdram_port_arbiter;

  localparam int AW   = 25;
  localparam int MAXR = 4;

  logic          clk_sys = 1'b0;
  logic          reset;
  logic [3:1]    req_drv;
  logic          cpu_we;
  logic [AW-1:0] dl_a, cpu_a, cas_a;
  logic [7:0]    dl_d, cpu_d;
  logic          mem_ack;
  logic [15:0]   mem_q;

  logic          dl_ack, cpu_ack, cas_ack, mem_req, mem_we, busy;
  logic [7:0]    cpu_q, cas_q;
  logic [AW-1:0] mem_a;
  logic [1:0]    mem_ds, grant;
  logic [15:0]   mem_d;

  always #5 clk_sys = ~clk_sys;

  sdram_port_arbiter #(.AW(AW), .CPU_MAX_RUN(MAXR)) dut (
    .clk_sys(clk_sys), .reset(reset),
    .dl_req(req_drv[1]), .dl_ack(dl_ack), .dl_a(dl_a), .dl_d(dl_d),
    .cpu_req(req_drv[2]), .cpu_ack(cpu_ack), .cpu_we(cpu_we), .cpu_a(cpu_a),
    .cpu_d(cpu_d), .cpu_q(cpu_q),
    .cas_req(req_drv[3]), .cas_ack(cas_ack), .cas_a(cas_a), .cas_q(cas_q),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_we(mem_we), .mem_a(mem_a),
    .mem_ds(mem_ds), .mem_d(mem_d), .mem_q(mem_q), .busy(busy), .grant(grant)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: outstanding requests per requester and expected outputs.
  bit   [3:1]    pend;
  logic [AW-1:0] ra [1:3];
  logic [7:0]    rd [1:3];
  bit            rwe [1:3];
  bit            m_wait;
  int            m_run, m_own;
  bit            granted_now;
  logic          e_req, e_busy, e_we;
  logic [1:0]    e_grant, e_ds;
  logic [3:1]    e_ack;
  logic [AW-1:0] e_a;
  logic [15:0]   e_d;
  logic [7:0]    e_cpu_q, e_cas_q;

  // Memory responder state.
  bit            resp_active;
  int            resp_cnt;
  int            delay;
  bit            ovr_en;
  logic [15:0]   ovr_q;

  int            gq[$];
  int            aq[$];
  logic [3:1]    prev_ack;

  typedef struct {
    logic          we;
    logic [AW-1:0] a;
    logic [7:0]    d;
    logic [15:0]   q;
    logic [1:0]    ds;
    logic [15:0]   md;
    logic [7:0]    eq;
  } vec_t;
  vec_t vecs [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] word_of(input logic [AW-1:0] a);
    logic [15:0] w;
    w = a[16:1];
    return (w * 16'h9E37) ^ 16'h1234;
  endfunction

  task automatic model_reset();
    pend = '0; m_wait = 0; m_run = 0; m_own = 0;
    e_req = 0; e_busy = 0; e_we = 0; e_grant = '0; e_ds = '0; e_ack = '0;
    e_a = '0; e_d = '0; e_cpu_q = '0; e_cas_q = '0;
    resp_active = 0; resp_cnt = 0; mem_ack = 1'b0;
    req_drv = '0;
    prev_ack = '0;
  endtask

  // Advance the model by the rising edge that just passed.
  task automatic step();
    int w;
    logic [7:0] q;
    granted_now = 0;
    if (reset) return;
    if (m_wait) begin
      if (mem_ack == e_req) begin
        e_ack[m_own] = ~e_ack[m_own];
        if (!e_we) begin
          q = e_a[0] ? mem_q[7:0] : mem_q[15:8];
          if (m_own == 2) e_cpu_q = q;
          else if (m_own == 3) e_cas_q = q;
        end
        pend[m_own] = 0;
        e_busy = 0;
        m_wait = 0;
      end
    end else begin
      w = 0;
      if (pend[1]) w = 1;
      else if (pend[3] && m_run == MAXR) w = 3;
      else if (pend[2]) w = 2;
      else if (pend[3]) w = 3;
      if (!pend[3] || w == 3) m_run = 0;
      else if (w == 2 && m_run < MAXR) m_run++;
      if (w != 0) begin
        e_a  = ra[w];
        e_we = (w == 1) ? 1'b1 : (w == 2) ? rwe[2] : 1'b0;
        if (w != 3) e_d = {rd[w], rd[w]};
        e_ds = {~ra[w][0], ra[w][0]};
        e_req = ~e_req;
        e_busy = 1;
        e_grant = 2'(w);
        m_own = w;
        m_wait = 1;
        granted_now = 1;
      end
    end
  endtask

  task automatic compare();
    chk("mem_req", 32'(mem_req), 32'(e_req));
    chk("busy",    32'(busy),    32'(e_busy));
    chk("grant",   32'(grant),   32'(e_grant));
    chk("dl_ack",  32'(dl_ack),  32'(e_ack[1]));
    chk("cpu_ack", 32'(cpu_ack), 32'(e_ack[2]));
    chk("cas_ack", 32'(cas_ack), 32'(e_ack[3]));
    chk("cpu_q",   32'(cpu_q),   32'(e_cpu_q));
    chk("cas_q",   32'(cas_q),   32'(e_cas_q));
    chk("mem_we",  32'(mem_we),  32'(e_we));
    chk("mem_a",   32'(mem_a),   32'(e_a));
    chk("mem_ds",  32'(mem_ds),  32'(e_ds));
    chk("mem_d",   32'(mem_d),   32'(e_d));
  endtask

  task automatic responder();
    if (reset) begin
      resp_active = 0;
      return;
    end
    if (!resp_active && mem_req != mem_ack) begin
      resp_active = 1;
      resp_cnt = delay;
    end
    if (resp_active) begin
      if (resp_cnt == 0) begin
        mem_q = ovr_en ? ovr_q : word_of(mem_a);
        mem_ack = ~mem_ack;
        resp_active = 0;
      end else begin
        resp_cnt--;
      end
    end
  endtask

  task automatic tick();
    logic [3:1] cur;
    @(negedge clk_sys);
    step();
    compare();
    if (granted_now) gq.push_back(int'(grant));
    cur = {cas_ack, cpu_ack, dl_ack};
    for (int i = 1; i <= 3; i++)
      if (cur[i] != prev_ack[i]) aq.push_back(i);
    prev_ack = cur;
    responder();
  endtask

  task automatic issue(input int r, input logic we, input logic [AW-1:0] a, input logic [7:0] d);
    if (pend[r]) return;
    pend[r] = 1;
    ra[r] = a;
    rd[r] = d;
    rwe[r] = (r == 1) ? 1'b1 : (r == 2) ? we : 1'b0;
    case (r)
      1: begin dl_a = a; dl_d = d; end
      2: begin cpu_a = a; cpu_d = d; cpu_we = we; end
      default: cas_a = a;
    endcase
    req_drv[r] = ~req_drv[r];
  endtask

  task automatic wait_done(input int bound, input string name);
    int n = 0;
    while (pend != 0 && n < bound) begin
      tick();
      n++;
    end
    chk(name, 32'(pend == 0), 32'd1);
  endtask

  task automatic wait_grant(input int bound, input string name);
    int n = 0;
    granted_now = 0;
    while (!granted_now && n < bound) begin
      tick();
      n++;
    end
    chk(name, 32'(granted_now), 32'd1);
  endtask

  task automatic chk_seq(input string name, input int got[$], input int exp[$]);
    chk({name, "_len"}, 32'(got.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size(); i++)
      chk(name, (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(exp[i]));
  endtask

  initial begin
    reset = 1'b1;
    cpu_we = 0; dl_a = '0; cpu_a = '0; cas_a = '0; dl_d = '0; cpu_d = '0;
    mem_q = '0; delay = 0; ovr_en = 0; ovr_q = '0;
    model_reset();
    repeat (3) tick();
    reset = 1'b0;

    // Directed CPU vectors: byte lanes, replication and read byte selection.
    vecs[0] = '{1'b1, 25'h00123, 8'hA5, 16'h0000, 2'b01, 16'hA5A5, 8'h00};
    vecs[1] = '{1'b0, 25'h00124, 8'h00, 16'h5A3C, 2'b10, 16'h0000, 8'h5A};
    vecs[2] = '{1'b0, 25'h00125, 8'h00, 16'h5A3C, 2'b01, 16'h0000, 8'h3C};
    ovr_en = 1;
    for (int i = 0; i < 3; i++) begin
      ovr_q = vecs[i].q;
      issue(2, vecs[i].we, vecs[i].a, vecs[i].d);
      wait_grant(10, "vec_grant");
      chk("vec_ds", 32'(mem_ds), 32'(vecs[i].ds));
      chk("vec_we", 32'(mem_we), 32'(vecs[i].we));
      if (vecs[i].we) chk("vec_md", 32'(mem_d), 32'(vecs[i].md));
      wait_done(20, "vec_done");
      chk("vec_q", 32'(cpu_q), 32'(vecs[i].eq));
      chk("vec_ack", 32'(cpu_ack), 32'((i + 1) & 1));
    end
    ovr_en = 0;

    // Simultaneous requests: grant and ack order follow priority.
    delay = 2;
    tick();
    gq.delete(); aq.delete();
    issue(1, 1'b1, 25'h0000A, 8'h11);
    issue(2, 1'b0, 25'h0000B, 8'h22);
    issue(3, 1'b0, 25'h0000C, 8'h33);
    wait_done(60, "prio_done");
    chk_seq("prio_grants", gq, '{1, 2, 3});
    chk_seq("prio_acks", aq, '{1, 2, 3});

    // CPU hammering with cassette pending: run limit forces a CAS grant.
    delay = 1;
    tick();
    gq.delete();
    issue(2, 1'b0, 25'h00200, 8'h00);
    issue(3, 1'b0, 25'h00301, 8'h00);
    for (int n = 0; n < 200 && gq.size() < 6; n++) begin
      tick();
      if (gq.size() < 5) issue(2, n[0], AW'(25'h00200 + n), 8'(n));
    end
    wait_done(40, "run_done");
    chk_seq("run_grants", gq, '{2, 2, 2, 2, 3, 2});

    // Long memory latency with a cassette request arriving mid-wait.
    delay = 20;
    tick();
    gq.delete();
    issue(2, 1'b1, 25'h01000, 8'h77);
    repeat (5) tick();
    issue(3, 1'b0, 25'h01001, 8'h00);
    wait_done(100, "slow_done");
    chk_seq("slow_grants", gq, '{2, 3});

    // Reset in the middle of a transaction.
    delay = 10;
    issue(2, 1'b0, 25'h00456, 8'h00);
    wait_grant(10, "rst_grant");
    repeat (3) tick();
    reset = 1'b1;
    #1;
    chk("rst_mem_req", 32'(mem_req), 0);
    chk("rst_busy",    32'(busy), 0);
    chk("rst_grant",   32'(grant), 0);
    chk("rst_acks",    32'({dl_ack, cpu_ack, cas_ack}), 0);
    chk("rst_mem_a",   32'(mem_a), 0);
    chk("rst_mem_d",   32'({mem_we, mem_ds, mem_d}), 0);
    chk("rst_q",       32'({cpu_q, cas_q}), 0);
    model_reset();
    repeat (2) tick();
    reset = 1'b0;
    delay = 0;
    issue(2, 1'b0, 25'h00457, 8'h00);
    wait_done(20, "post_rst_done");
    chk("post_rst_ack", 32'(cpu_ack), 32'd1);

    // Randomized traffic against the model.
    for (int n = 0; n < 400; n++) begin
      tick();
      if (!resp_active) delay = $urandom_range(0, 4);
      for (int r = 1; r <= 3; r++)
        if ($urandom_range(0, 3) == 0)
          issue(r, 1'($urandom), AW'($urandom), 8'($urandom));
    end
    wait_done(200, "rand_done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
